alu_serial_ctrl: RTL and testbench

Bit-serial sequencer that drives the team's 1-bit ALU slice (Mode/A/B/C_in in, X/C_out out) from the controller side. It accepts W-bit operands and an opcode and presents one bit pair per cycle, LSB first. It feeds C_out back as C_in for add and assembles X into a W-bit result. It sits between a register file or bus and a single combinational ALU slice.

---
 rtl/alu_serial_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial controller for the 1-bit ALU slice, LSB first.
// Define ALU_SERIAL_OVF_EN to add the signed-overflow output OVF.
module alu_serial_ctrl #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         START,
  output logic         READY,
  input  logic [2:0]   OP,
  input  logic [W-1:0] OPA,
  input  logic [W-1:0] OPB,
  input  logic         CIN,
  output logic [2:0]   ALU_MODE,
  output logic         ALU_A,
  output logic         ALU_B,
  output logic         ALU_CIN,
  input  logic         ALU_X,
  input  logic         ALU_COUT,
  output logic [W-1:0] RESULT,
  output logic         CARRY,
  output logic         DONE,
`ifdef ALU_SERIAL_OVF_EN
  output logic         ERR,
  output logic         OVF
`else
  output logic         ERR
`endif
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [2:0] OP_ADD = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]    mode_q;
  logic [W-1:0]  sha_q;
  logic [W-1:0]  shb_q;
  logic          carry_q;
  logic [W-1:0]  result_q;
  logic          carry_o_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic accept;
  logic run;
  logic last;
  logic op_legal;
  logic is_add;

  assign is_add = (mode_q == OP_ADD);

  // Opcode legality: add and the four logic ops only.
  always_comb begin
    op_legal = 1'b0;
    unique case (1'b1)
      (OP == 3'b000): op_legal = 1'b1;
      (OP == 3'b001): op_legal = 1'b1;
      (OP == 3'b010): op_legal = 1'b1;
      (OP == 3'b011): op_legal = 1'b1;
      (OP == 3'b100): op_legal = 1'b1;
      default:        op_legal = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_d = state_q;
    READY   = 1'b0;
    DONE    = 1'b0;
    accept  = 1'b0;
    run     = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        READY = 1'b1;
        if (START) begin
          accept  = 1'b1;
          state_d = op_legal ? S_RUN : S_FIN;
        end
      end
      S_RUN: begin
        run = 1'b1;
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        DONE    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Slice drive: bits only while running, carry chain only for add.
  always_comb begin
    ALU_MODE = mode_q;
    ALU_A    = run & sha_q[0];
    ALU_B    = run & shb_q[0];
    ALU_CIN  = run & is_add & carry_q;
  end

  // Operand shifting, carry feedback and result assembly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q    <= '0;
      sha_q     <= '0;
      shb_q     <= '0;
      carry_q   <= 1'b0;
      result_q  <= '0;
      carry_o_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      mode_q    <= OP;
      sha_q     <= OPA;
      shb_q     <= OPB;
      carry_q   <= CIN;
      result_q  <= '0;
      carry_o_q <= 1'b0;
      err_q     <= ~op_legal;
      cnt_q     <= '0;
    end else if (run) begin
      result_q <= W'({ALU_X, result_q} >> 1);
      carry_q  <= is_add & ALU_COUT;
      sha_q    <= sha_q >> 1;
      shb_q    <= shb_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (last) begin
        carry_o_q <= is_add & ALU_COUT;
      end
    end
  end

`ifdef ALU_SERIAL_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into vs out of the sign bit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (run && last) begin
      ovf_q <= is_add & (ALU_CIN ^ ALU_COUT);
    end
  end

  assign OVF = ovf_q;
`endif

  assign RESULT = result_q;
  assign CARRY  = carry_o_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl with a behavioural ALU slice.
// Define ALU_SERIAL_OVF_EN to also exercise OVF.
module tb_alu_serial_ctrl;

  localparam int W = 8;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic         READY;
  logic [2:0]   OP;
  logic [W-1:0] OPA;
  logic [W-1:0] OPB;
  logic         CIN;
  logic [2:0]   ALU_MODE;
  logic         ALU_A;
  logic         ALU_B;
  logic         ALU_CIN;
  logic         ALU_X;
  logic         ALU_COUT;
  logic [W-1:0] RESULT;
  logic         CARRY;
  logic         DONE;
  logic         ERR;
`ifdef ALU_SERIAL_OVF_EN
  logic         OVF;
`endif

  int checks;
  int failures;

  alu_serial_ctrl #(.W(W)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .START(START),
    .READY(READY),
    .OP(OP),
    .OPA(OPA),
    .OPB(OPB),
    .CIN(CIN),
    .ALU_MODE(ALU_MODE),
    .ALU_A(ALU_A),
    .ALU_B(ALU_B),
    .ALU_CIN(ALU_CIN),
    .ALU_X(ALU_X),
    .ALU_COUT(ALU_COUT),
    .RESULT(RESULT),
    .CARRY(CARRY),
    .DONE(DONE),
`ifdef ALU_SERIAL_OVF_EN
    .ERR(ERR),
    .OVF(OVF)
`else
    .ERR(ERR)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural slice; carry-out is always the majority so that
  // any missing carry gating in the controller becomes visible.
  always_comb begin
    ALU_COUT = (ALU_A & ALU_B) | (ALU_A & ALU_CIN) | (ALU_B & ALU_CIN);
    case (ALU_MODE)
      3'b000:  ALU_X = ALU_A ^ ALU_B ^ ALU_CIN;
      3'b001:  ALU_X = ALU_A & ALU_B;
      3'b010:  ALU_X = ALU_A | ALU_B;
      3'b011:  ALU_X = ALU_A ^ ALU_B;
      3'b100:  ALU_X = ~(ALU_A ^ ALU_B);
      default: ALU_X = 1'b0;
    endcase
  end

  task automatic check(input logic [31:0] obs,
                       input logic [31:0] exp,
                       input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] op,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic cin,
                        input logic [W-1:0] er,
                        input logic ec,
                        input logic ee,
                        input logic eo,
                        input int inj,
                        input string tag);
    logic c;
    logic pc;
    logic legal;
    legal = (op <= 3'd4);
    @(negedge CLK);
    check(32'(READY), 32'd1, {tag, ":ready"});
    START = 1'b1;
    OP    = op;
    OPA   = a;
    OPB   = b;
    CIN   = cin;
    @(posedge CLK);
    #1;
    START = 1'b0;
    OPA   = ~a;
    OPB   = ~b;
    CIN   = ~cin;
    c  = cin;
    pc = cin;
    if (legal) begin
      for (int k = 0; k < W; k++) begin
        @(negedge CLK);
        check(32'(DONE), 32'd0, {tag, ":done_early"});
        check(32'(ALU_A), 32'(a[k]), {tag, ":alu_a"});
        check(32'(ALU_B), 32'(b[k]), {tag, ":alu_b"});
        check(32'(ALU_MODE), 32'(op), {tag, ":mode"});
        if (op == 3'b000) begin
          check(32'(ALU_CIN), 32'(c), {tag, ":cin_chain"});
          if (k > 0) check(32'(ALU_CIN), 32'(pc), {tag, ":cin_prev"});
          c = (a[k] & b[k]) | (a[k] & c) | (b[k] & c);
        end else begin
          check(32'(ALU_CIN), 32'd0, {tag, ":cin_zero"});
        end
        pc = ALU_COUT;
        if (k == inj) begin
          START = 1'b1;
          OP    = 3'b010;
          OPA   = 8'h00;
          OPB   = 8'h00;
        end
        if (k == inj + 1) START = 1'b0;
      end
      START = 1'b0;
    end
    @(negedge CLK);
    check(32'(DONE), 32'd1, {tag, ":done"});
    check(32'(READY), 32'd0, {tag, ":ready_fin"});
    check(32'(RESULT), 32'(er), {tag, ":result"});
    check(32'(CARRY), 32'(ec), {tag, ":carry"});
    check(32'(ERR), 32'(ee), {tag, ":err"});
    check(32'(ALU_A), 32'd0, {tag, ":a_idle"});
    check(32'(ALU_B), 32'd0, {tag, ":b_idle"});
    check(32'(ALU_CIN), 32'd0, {tag, ":cin_idle"});
`ifdef ALU_SERIAL_OVF_EN
    check(32'(OVF), 32'(eo), {tag, ":ovf"});
`else
    if (eo === 1'bx) $display("unexpected x");
`endif
    @(negedge CLK);
    check(32'(DONE), 32'd0, {tag, ":done_pulse"});
    check(32'(READY), 32'd1, {tag, ":ready_back"});
    check(32'(RESULT), 32'(er), {tag, ":result_hold"});
    check(32'(CARRY), 32'(ec), {tag, ":carry_hold"});
    check(32'(ERR), 32'(ee), {tag, ":err_hold"});
    check(32'(ALU_MODE), 32'(op), {tag, ":mode_hold"});
  endtask

  initial begin
    int done_seen;
    checks   = 0;
    failures = 0;
    RST_N = 1'b0;
    START = 1'b0;
    OP    = 3'b000;
    OPA   = '0;
    OPB   = '0;
    CIN   = 1'b0;
    #1;
    check(32'(READY), 32'd1, "rst:ready");
    check(32'(DONE), 32'd0, "rst:done");
    check(32'(ERR), 32'd0, "rst:err");
    check(32'(CARRY), 32'd0, "rst:carry");
    check(32'(RESULT), 32'h00, "rst:result");
    check(32'(ALU_MODE), 32'd0, "rst:mode");
    check(32'({ALU_A, ALU_B, ALU_CIN}), 32'd0, "rst:abc");
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;

    run_op(3'b000, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b0, 1'b0, -9, "add5a33");
    run_op(3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, -9, "addff01");
    run_op(3'b000, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, -9, "addff00c");
    run_op(3'b001, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, -9, "and");
    run_op(3'b010, 8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0, -9, "or");
    run_op(3'b011, 8'hF0, 8'h3C, 1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, -9, "xor");
    run_op(3'b100, 8'hF0, 8'h3C, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, -9, "xnor");
    run_op(3'b101, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, -9, "ill101");
    run_op(3'b111, 8'hAA, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, -9, "ill111");
    run_op(3'b000, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 3, "startrun");

    @(negedge CLK);
    START = 1'b1;
    OP    = 3'b000;
    OPA   = 8'h5A;
    OPB   = 8'h33;
    CIN   = 1'b0;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (5) @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check(32'(READY), 32'd1, "midrst:ready");
    check(32'(DONE), 32'd0, "midrst:done");
    check(32'(RESULT), 32'h00, "midrst:result");
    check(32'(CARRY), 32'd0, "midrst:carry");
    check(32'(ERR), 32'd0, "midrst:err");
    check(32'(ALU_MODE), 32'd0, "midrst:mode");
    check(32'({ALU_A, ALU_B, ALU_CIN}), 32'd0, "midrst:abc");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    done_seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge CLK);
      if (DONE) done_seen++;
    end
    check(32'(done_seen), 32'd0, "midrst:no_done");
    run_op(3'b000, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, -9, "add0101");

`ifdef ALU_SERIAL_OVF_EN
    run_op(3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, -9, "ovf7f01");
    run_op(3'b000, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, -9, "ovf8080");
    run_op(3'b001, 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, -9, "ovfand");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
